// File: rtl/reg_file32.sv
// 32 x 32-bit RV32I integer register file: two combinational read ports, one write port, x0 reads zero.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 2 ** ADDR_W;

    // No handshake: we qualifies waddr/wdata for exactly the cycle it is high;
    // with we=0 those inputs are ignored, so unknowns there cannot reach storage.
    logic [DATA_W-1:0] mem [1:NREGS-1];
    logic              wr_hit;

    assign wr_hit = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[waddr] <= wdata;
        end
    end

    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (raddr1 != '0) begin
            stored1 = mem[raddr1];
        end
        if (raddr2 != '0) begin
            stored2 = mem[raddr2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is blocked during reset so the write that reset discards is never seen.
    logic fwd1;
    logic fwd2;

    assign fwd1 = wr_hit && !reset && (raddr1 == waddr);
    assign fwd2 = wr_hit && !reset && (raddr2 == waddr);

    assign rdata1 = fwd1 ? wdata : stored1;
    assign rdata2 = fwd2 ? wdata : stored2;
`else
    assign rdata1 = stored1;
    assign rdata2 = stored2;
`endif

endmodule
